comparator_offset_cal: RTL and testbench
========================================

Name: comparator_offset_cal

Overview:
- Clocked foreground offset-calibration controller for the continuous-time comparator.
- Drives the comparator's 5-bit trim buses `cfg_offset_p` and `cfg_offset_n` (1 mV/LSB each) and reads back its `out` decision.
- On `start`: asserts `cal_en` to short the comparator inputs, finds the sign of the offset, then runs a 5-step successive-approximation search on the trim magnitude.
- Holds the final code and also accepts a direct software code load.

Parameters:
- SETTLE_CYC, 16: clock cycles waited after any trim/cal_en change before sampling; must be ≥ 3 (covers 2-flop sync).
- N_VOTE, 5: samples per decision, odd, 1..15; used only when the vote feature is compiled in.
- CODE_W, 5: trim magnitude width; fixed to match the comparator.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  1-cycle pulse; begins calibration; ignored while busy
- cmp_out  in  1  comparator output, asynchronous to clk; double-flop synchronised internally
- cfg_wr  in  1  manual code load strobe; honoured only when busy=0
- cfg_code  in  6  signed two's-complement manual code; positive→p trim, negative→n trim, −32 saturates to −31
- cfg_offset_p  out  5  comparator positive trim, binary
- cfg_offset_n  out  5  comparator negative trim, bit-reversed (the comparator un-reverses it internally)
- cal_en  out  1  shorts comparator inputs during calibration
- busy  out  1  calibration in progress
- done  out  1  calibration complete; sticky until next start, cfg_wr or rst
- cal_code  out  6  signed result: +p magnitude or −n magnitude
- cal_sat  out  1  search railed at magnitude 31 and offset still uncorrected

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; vote and settle counters cleared.
- Reset mid-calibration: aborts on the next edge; trims return to 0.
- FSM states: IDLE, SETTLE, VOTE, DECIDE, DONE.
- IDLE/DONE + start:
  - trims set to 0; cal_en=1, busy=1, done=0.
  - step index = SIGN; go to SETTLE.
- SETTLE: counts SETTLE_CYC cycles, then goes to VOTE.
- VOTE: samples the synchronised cmp_out for N_VOTE cycles; decision = majority of ones; then DECIDE.
- DECIDE, SIGN step:
  - decision=1 (offset ≥ 0): side=N; decision=0: side=P.
  - Trial bit 4 set on the chosen side; go to SETTLE.
- DECIDE, bit-k step (k = 4 down to 0):
  - keep = (side==N) ? decision==1 : decision==0; clear bit k if !keep.
  - k>0: set trial bit k−1, then SETTLE.
  - k==0: go to DONE.
- DONE entry (one cycle after final DECIDE):
  - cal_en=0, busy=0, done=1.
  - cal_code = side==P ? +mag : −mag.
  - cal_sat = (mag==31 && last keep==1).
  - Trims held.
- Trim mapping: side P → cfg_offset_p=mag, cfg_offset_n=0; side N → cfg_offset_p=0, cfg_offset_n=bitrev(mag).
- Trim outputs are registered and change only in DECIDE or on cfg_wr/start.
- Latency: 6 steps × (SETTLE_CYC + N_VOTE + 1) cycles, plus 1 cycle for DONE. Defaults give 133 cycles from the start edge to done=1.
- cfg_wr while busy=0:
  - loads trims from cfg_code next cycle; cal_code=cfg_code (−32 → −31); done=0; cal_sat=0.
  - If start and cfg_wr occur in the same cycle, start wins.
- start or cfg_wr while busy=1: ignored.
- cmp_out glitches between samples have no effect; only synchronised values during VOTE matter.

Optional Feature:
- Macro: OFFSET_CAL_VOTE_EN.
- Defined: majority vote over N_VOTE samples, using sub-module cal_vote_counter.
- Undefined: single sample per decision (N_VOTE treated as 1); per-step cost SETTLE_CYC+2 cycles; defaults give 109 cycles to done.

Decomposition:
- Package comparator_cal_pkg:
  - cal_state_e enum; cal_side_e {SIDE_P, SIDE_N}; CODE_W=5.
  - Function bitrev5.
  - Function code_to_trim (signed code → p/n buses).
- Sub-module cal_vote_counter:
  - Inputs: clk, rst, clear, sample, bit_in.
  - Output: majority.
  - 4-bit ones counter; instantiated only under OFFSET_CAL_VOTE_EN.

Test Plan:
- Behavioural comparator with intrinsic offset +7.3 mV, start → side N, mag 7, cfg_offset_n=5'b11100, cfg_offset_p=0, cal_code=−7, done at cycle 133, cal_sat=0.
- Intrinsic offset −12.4 mV → cfg_offset_p=12, cfg_offset_n=0, cal_code=+12.
- Intrinsic offset +40 mV → mag 31, cfg_offset_n=5'b11111, cal_sat=1; −40 mV → cfg_offset_p=31, cal_sat=1.
- Assert rst at cycle 60 of a calibration → all outputs 0 on the next edge; start pulse mid-run ignored; cfg_wr=−5 when idle → cfg_offset_n=5'b10100, cal_code=−5, done=0.
- OFFSET_CAL_VOTE_EN defined, cmp_out flipped on 2 of 5 samples per VOTE → same result as the noise-free run. Undefined build → done at cycle 109.

Source files
------------

// File: rtl/comparator_cal_pkg.sv
// Shared state/side types and signed-code to trim-bus mapping for comparator_offset_cal.
package comparator_cal_pkg;

  localparam int CODE_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_VOTE   = 3'd2,
    ST_DECIDE = 3'd3,
    ST_DONE   = 3'd4
  } cal_state_e;

  typedef enum logic {
    SIDE_P = 1'b0,
    SIDE_N = 1'b1
  } cal_side_e;

  typedef struct packed {
    logic [CODE_W-1:0] p;
    logic [CODE_W-1:0] n;
  } trim_t;

  function automatic logic [4:0] bitrev5(input logic [4:0] v);
    return {v[0], v[1], v[2], v[3], v[4]};
  endfunction

  // -32 has no representable magnitude on a 5-bit trim, so it clamps to -31.
  function automatic logic [5:0] sat_code(input logic [5:0] c);
    return (c == 6'b100000) ? 6'b100001 : c;
  endfunction

  function automatic logic [5:0] side_code(input cal_side_e s, input logic [4:0] m);
    return (s == SIDE_P) ? {1'b0, m} : -{1'b0, m};
  endfunction

  function automatic trim_t code_to_trim(input logic [5:0] code);
    trim_t      t;
    logic [5:0] c;
    logic [5:0] mag;
    c   = sat_code(code);
    t   = '0;
    mag = -c;
    if (c[5]) t.n = bitrev5(mag[4:0]);
    else      t.p = c[4:0];
    return t;
  endfunction

endpackage

// File: rtl/cal_vote_counter.sv
// Ones counter over one VOTE window; majority is combinational from the count.
// Held at zero by clear, so the count only spans the current decision.
module cal_vote_counter #(
  parameter int N_VOTE = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic sample,
  input  logic bit_in,
  output logic majority
);

  logic [3:0] ones;

  always_ff @(posedge clk) begin
    if (rst || clear)          ones <= '0;
    else if (sample && bit_in) ones <= ones + 4'd1;
  end

  assign majority = (ones > 4'(N_VOTE / 2));

endmodule

// File: rtl/comparator_offset_cal.sv
// Foreground offset cal: sign detect then 5-bit SAR on trim magnitude; 6*(SETTLE_CYC+votes+1)+1 cycles to done.
// start/cfg_wr are ignored while busy; OFFSET_CAL_VOTE_EN enables N_VOTE majority voting per decision.
module comparator_offset_cal
  import comparator_cal_pkg::*;
#(
  parameter int SETTLE_CYC = 16,
  parameter int N_VOTE     = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cmp_out,
  input  logic       cfg_wr,
  input  logic [5:0] cfg_code,
  output logic [4:0] cfg_offset_p,
  output logic [4:0] cfg_offset_n,
  output logic       cal_en,
  output logic       busy,
  output logic       done,
  output logic [5:0] cal_code,
  output logic       cal_sat
);

`ifdef OFFSET_CAL_VOTE_EN
  localparam int NV = N_VOTE;
`else
  localparam int NV = (N_VOTE > 0) ? 1 : 1;
`endif
  localparam int         SCW       = $clog2(SETTLE_CYC);
  localparam logic [2:0] STEP_SIGN = 3'd5;

  cal_state_e        state;
  logic [SCW-1:0]    settle_cnt;
  logic [3:0]        vote_cnt;
  logic [2:0]        step;
  cal_side_e         side;
  logic [CODE_W-1:0] mag;
  logic              last_keep;
  logic              sync1, sync2;
  logic              decision;

`ifdef OFFSET_CAL_VOTE_EN
  cal_vote_counter #(.N_VOTE(NV)) u_vote (
    .clk      (clk),
    .rst      (rst),
    .clear    (state != ST_VOTE && state != ST_DECIDE),
    .sample   (state == ST_VOTE),
    .bit_in   (sync2),
    .majority (decision)
  );
`else
  logic smp;
  always_ff @(posedge clk) begin
    if (rst)                   smp <= 1'b0;
    else if (state == ST_VOTE) smp <= sync2;
  end
  assign decision = smp;
`endif

  logic              keep;
  logic [CODE_W-1:0] bit_mask;
  logic [CODE_W-1:0] next_mag;
  cal_side_e         next_side;

  // Clear the bit under test if it overcorrected, then raise the next trial bit.
  always_comb begin
    keep      = (side == SIDE_N) ? decision : !decision;
    bit_mask  = 5'b00001 << step;
    next_side = side;
    next_mag  = mag;
    if (step == STEP_SIGN) begin
      next_side = decision ? SIDE_N : SIDE_P;
      next_mag  = 5'b10000;
    end else begin
      if (!keep) next_mag = mag & ~bit_mask;
      next_mag = next_mag | (bit_mask >> 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      settle_cnt   <= '0;
      vote_cnt     <= '0;
      step         <= '0;
      side         <= SIDE_P;
      mag          <= '0;
      last_keep    <= 1'b0;
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      cfg_offset_p <= '0;
      cfg_offset_n <= '0;
      cal_en       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cal_code     <= '0;
      cal_sat      <= 1'b0;
    end else begin
      sync1 <= cmp_out;
      sync2 <= sync1;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (busy) begin
            cal_en   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            cal_code <= side_code(side, mag);
            cal_sat  <= (mag == 5'd31) && last_keep;
          end else if (start) begin
            cfg_offset_p <= '0;
            cfg_offset_n <= '0;
            cal_en       <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            cal_sat      <= 1'b0;
            step         <= STEP_SIGN;
            mag          <= '0;
            settle_cnt   <= '0;
            state        <= ST_SETTLE;
          end else if (cfg_wr) begin
            {cfg_offset_p, cfg_offset_n} <= code_to_trim(cfg_code);
            cal_code <= sat_code(cfg_code);
            done     <= 1'b0;
            cal_sat  <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SCW'(SETTLE_CYC - 1)) begin
            settle_cnt <= '0;
            vote_cnt   <= '0;
            state      <= ST_VOTE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_VOTE: begin
          if (vote_cnt == 4'(NV - 1)) state <= ST_DECIDE;
          else                        vote_cnt <= vote_cnt + 4'd1;
        end
        ST_DECIDE: begin
          side <= next_side;
          mag  <= next_mag;
          {cfg_offset_p, cfg_offset_n} <= code_to_trim(side_code(next_side, next_mag));
          if (step == STEP_SIGN) begin
            step  <= 3'd4;
            state <= ST_SETTLE;
          end else begin
            last_keep <= keep;
            if (step == 3'd0) begin
              state <= ST_DONE;
            end else begin
              step  <= step - 3'd1;
              state <= ST_SETTLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_offset_cal.sv
// Bench for comparator_offset_cal: behavioural comparator plus arithmetic model of the expected trim result.
// Build with OFFSET_CAL_VOTE_EN defined to exercise the majority-vote noise case.
module tb_comparator_offset_cal;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cmp_out = 1'b0;
  logic       cfg_wr = 1'b0;
  logic [5:0] cfg_code = '0;
  logic [4:0] cfg_offset_p, cfg_offset_n;
  logic       cal_en, busy, done, cal_sat;
  logic [5:0] cal_code;

  always #5 clk = ~clk;

  comparator_offset_cal dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cmp_out      (cmp_out),
    .cfg_wr       (cfg_wr),
    .cfg_code     (cfg_code),
    .cfg_offset_p (cfg_offset_p),
    .cfg_offset_n (cfg_offset_n),
    .cal_en       (cal_en),
    .busy         (busy),
    .done         (done),
    .cal_code     (cal_code),
    .cal_sat      (cal_sat)
  );

`ifdef OFFSET_CAL_VOTE_EN
  localparam int LAT = 133;
  localparam int PERIOD = 22;
`else
  localparam int LAT = 109;
  localparam int PERIOD = 18;
`endif

  int          checks = 0;
  int          errors = 0;
  int          off10 = 0;     // intrinsic offset in 0.1 mV
  bit          noise_en = 1'b0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          mode = 0;      // 0 idle-unchecked, 1 calibrating, 2 steady expected
  logic [19:0] exp_vec = '0;
  wire  [19:0] out_vec = {busy, cal_en, done, cal_sat, cfg_offset_p, cfg_offset_n, cal_code};

  function automatic logic [4:0] rev(input logic [4:0] v);
    logic [4:0] r;
    for (int i = 0; i < 5; i++) r[i] = v[4-i];
    return r;
  endfunction

  function automatic logic [19:0] mk(input logic b, input logic ce, input logic d, input logic s,
                                     input logic [4:0] p, input logic [4:0] n, input logic [5:0] c);
    return {b, ce, d, s, p, n, c};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // Comparator with shorted inputs: output sign of offset plus p trim minus n trim.
  always @(posedge clk) begin
    int  eff;
    int  ph;
    bit  flip;
    #1;
    eff  = off10 + 10 * int'(cfg_offset_p) - 10 * int'(rev(cfg_offset_n));
    ph   = (cyc - start_cyc) % PERIOD;
    flip = noise_en && busy && (ph == 16 || ph == 17);
    cmp_out = (eff >= 0) ^ flip;
  end

  always @(negedge clk) begin
    if (mode == 1)      chk("busy_phase", {busy, cal_en, done}, 3'b110);
    else if (mode == 2) chk("steady_outputs", out_vec, exp_vec);
  end

  // Expected SAR result: largest magnitude that does not overcorrect the offset.
  task automatic model_cal(input int o, output logic [19:0] v);
    int m;
    logic s;
    if (o >= 0) begin
      m = o / 10;
      if (m > 31) m = 31;
      s = (m == 31) && (o - 310 >= 0);
      v = mk(1'b0, 1'b0, 1'b1, s, 5'd0, rev(5'(m)), 6'(-m));
    end else begin
      m = (-o - 1) / 10;
      if (m > 31) m = 31;
      s = (m == 31) && (o + 310 < 0);
      v = mk(1'b0, 1'b0, 1'b1, s, 5'(m), 5'd0, 6'(m));
    end
  endtask

  task automatic run_cal(input int o, input int rst_at, input bit disturb, input bit with_wr,
                         output int lat);
    logic [19:0] v;
    off10 = o;
    @(posedge clk); #1;
    start = 1'b1;
    if (with_wr) begin cfg_wr = 1'b1; cfg_code = 6'd3; end
    @(posedge clk); #1;
    start = 1'b0;
    cfg_wr = 1'b0;
    start_cyc = cyc;
    mode = 1;
    lat = -1;
    for (int k = 1; k <= 400; k++) begin
      if (disturb && k == 30) start = 1'b1;
      if (disturb && k == 31) start = 1'b0;
      if (disturb && k == 40) begin cfg_wr = 1'b1; cfg_code = 6'd9; end
      if (disturb && k == 41) cfg_wr = 1'b0;
      if (k == rst_at) rst = 1'b1;
      @(posedge clk); #1;
      if (k == rst_at) begin
        rst = 1'b0;
        exp_vec = '0;
        mode = 2;
        chk("rst_abort", out_vec, 20'd0);
        lat = k;
        return;
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      chk("done_timeout", done, 1);
      mode = 0;
      return;
    end
    model_cal(o, v);
    exp_vec = v;
    mode = 2;
  endtask

  task automatic load(input logic [5:0] c);
    int v;
    @(posedge clk); #1;
    cfg_wr = 1'b1;
    cfg_code = c;
    @(posedge clk); #1;
    cfg_wr = 1'b0;
    v = int'($signed(c));
    if (v == -32) v = -31;
    if (v >= 0) exp_vec = mk(1'b0, 1'b0, 1'b0, 1'b0, 5'(v), 5'd0, 6'(v));
    else        exp_vec = mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, rev(5'(-v)), 6'(v));
    mode = 2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_state", out_vec, 20'd0);
    exp_vec = '0;
    mode = 2;
    repeat (2) @(posedge clk);

    // +7.3 mV: side N, magnitude 7
    run_cal(73, 0, 1'b0, 1'b0, lat);
    chk("latency_p73", lat, LAT);
    chk("p73_trim_n", cfg_offset_n, 5'b11100);
    chk("p73_trim_p", cfg_offset_p, 5'd0);
    chk("p73_code", cal_code, 6'b111001);
    chk("p73_sat", cal_sat, 1'b0);
    repeat (3) @(posedge clk);

    // -12.4 mV with start and cfg_wr pulses mid-run that must be ignored
    run_cal(-124, 0, 1'b1, 1'b0, lat);
    chk("latency_m124", lat, LAT);
    chk("m124_trim_p", cfg_offset_p, 5'd12);
    chk("m124_code", cal_code, 6'd12);
    repeat (3) @(posedge clk);

    load(6'b111011);
    chk("wr_m5_trim_n", cfg_offset_n, 5'b10100);
    chk("wr_m5_code", cal_code, 6'b111011);
    chk("wr_m5_done", done, 1'b0);
    repeat (3) @(posedge clk);

    // start and cfg_wr together: start wins
    run_cal(400, 0, 1'b0, 1'b1, lat);
    chk("p400_trim_n", cfg_offset_n, 5'b11111);
    chk("p400_sat", cal_sat, 1'b1);
    repeat (3) @(posedge clk);

    run_cal(-400, 0, 1'b0, 1'b0, lat);
    chk("m400_trim_p", cfg_offset_p, 5'd31);
    chk("m400_sat", cal_sat, 1'b1);
    repeat (3) @(posedge clk);

    load(6'b100000);
    chk("wr_m32_code", cal_code, 6'b100001);
    repeat (2) @(posedge clk);
    load(6'd13);
    repeat (2) @(posedge clk);

    run_cal(73, 60, 1'b0, 1'b0, lat);
    repeat (4) @(posedge clk);

`ifdef OFFSET_CAL_VOTE_EN
    noise_en = 1'b1;
    run_cal(73, 0, 1'b0, 1'b0, lat);
    noise_en = 1'b0;
    chk("noisy_p73_trim_n", cfg_offset_n, 5'b11100);
    chk("noisy_p73_code", cal_code, 6'b111001);
    repeat (3) @(posedge clk);
`endif

    mode = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
